sipo_receiver: RTL and testbench

Serial-in, parallel-out receiver that reassembles words sent LSB-first by the team's 4-bit parallel-load shift-register transmitter. It samples one bit per enabled clock and counts bits to find word boundaries. Each completed word goes to a double-buffered output register with a valid/ack handshake and a sticky overrun flag. It sits at the receiving end of the serial link, between the link wire and the consuming logic.

---
 rtl/sipo_receiver.sv | 62 ++++++
 tb/tb_sipo_receiver.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/sipo_receiver.sv
// LSB-first serial-in/parallel-out receiver with a double-buffered
// holding register, valid/ack handshake and sticky overrun flag.
module sipo_receiver #(
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     serialIn,
  input  logic                     shiftEN,
  input  logic                     ack,
  output logic [WIDTH-1:0]         content,
  output logic                     valid,
  output logic                     overrun,
  output logic [$clog2(WIDTH)-1:0] count
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // bit 0 of the shift path is never read back, so only the upper bits are kept
  logic [WIDTH-1:1] sreg;
  logic [WIDTH-1:0] word;
  logic             sample;
  logic             done;

  assign word   = {serialIn, sreg};
  assign sample = shiftEN && !clear;
  assign done   = sample && (count == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      sreg    <= '0;
      count   <= '0;
      content <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (clear) begin
        sreg    <= '0;
        count   <= '0;
        overrun <= 1'b0;
      end else if (shiftEN) begin
        sreg  <= word[WIDTH-1:1];
        count <= done ? '0 : count + 1'b1;
      end

      // an ack on the completion edge frees the holding register for the new word
      if (done) begin
        if (!valid || ack) begin
          content <= word;
          valid   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (ack) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_receiver.sv
// Directed and randomized bench for sipo_receiver against a
// queue-based model of the received bit stream.
module tb_sipo_receiver;

  localparam int W  = 4;
  localparam int CW = $clog2(W);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          clear = 1'b0;
  logic          serialIn = 1'b0;
  logic          shiftEN = 1'b0;
  logic          ack = 1'b0;
  logic [W-1:0]  content;
  logic          valid;
  logic          overrun;
  logic [CW-1:0] count;

  sipo_receiver #(.WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .clear(clear),
    .serialIn(serialIn),
    .shiftEN(shiftEN),
    .ack(ack),
    .content(content),
    .valid(valid),
    .overrun(overrun),
    .count(count)
  );

  always #5 clk = ~clk;

  int n_eval = 0;
  int n_fail = 0;

  bit           q[$];
  logic [W-1:0] m_content = '0;
  logic         m_valid = 1'b0;
  logic         m_ovr = 1'b0;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_eval++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic r, c, e, b, a);
    logic [W-1:0] w;
    bit done;
    done = 0;
    w = '0;
    if (r) begin
      q.delete();
      m_content = '0;
      m_valid = 1'b0;
      m_ovr = 1'b0;
    end else begin
      if (c) begin
        q.delete();
        m_ovr = 1'b0;
      end else if (e) begin
        q.push_back(b);
        if (q.size() == W) begin
          foreach (q[i]) if (q[i]) w[i] = 1'b1;
          q.delete();
          done = 1;
        end
      end
      if (done) begin
        if (!m_valid || a) begin
          m_content = w;
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (a) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic step(input logic r, c, e, b, a);
    reset = r;
    clear = c;
    shiftEN = e;
    serialIn = b;
    ack = a;
    model(r, c, e, b, a);
    @(posedge clk);
    #1;
    chk("count", 16'(count), 16'(q.size()));
    chk("content", 16'(content), 16'(m_content));
    chk("valid", 16'(valid), 16'(m_valid));
    chk("overrun", 16'(overrun), 16'(m_ovr));
  endtask

  task automatic bitin(input logic b, input logic a = 1'b0);
    step(1'b0, 1'b0, 1'b1, b, a);
  endtask

  task automatic idle(input logic a = 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, a);
  endtask

  task automatic send(input logic [W-1:0] w, input logic ack_last);
    for (int i = 0; i < W; i++)
      bitin(w[i], (i == W - 1) ? ack_last : 1'b0);
  endtask

  initial begin
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("rst_valid", 16'(valid), 16'h0);

    bitin(1); bitin(1); bitin(0); bitin(1);
    chk("plan_B", 16'(content), 16'hB);
    chk("plan_B_valid", 16'(valid), 16'h1);
    idle(1'b1);
    chk("ack_content", 16'(content), 16'hB);

    bitin(0); idle(); idle(); idle();
    chk("gap_count", 16'(count), 16'h1);
    bitin(1); idle(); idle(); idle();
    bitin(1); idle(); idle(); idle();
    bitin(0);
    chk("plan_6", 16'(content), 16'h6);
    idle(1'b1);

    send(4'h5, 1'b0);
    chk("b2b_5", 16'(content), 16'h5);
    send(4'hA, 1'b1);
    chk("b2b_A", 16'(content), 16'hA);
    chk("b2b_ovr", 16'(overrun), 16'h0);
    idle(1'b1);

    send(4'h3, 1'b0);
    send(4'hC, 1'b0);
    chk("ovr_keep3", 16'(content), 16'h3);
    chk("ovr_set", 16'(overrun), 16'h1);
    idle(1'b1);
    chk("ovr_sticky", 16'(overrun), 16'h1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ovr_clr", 16'(overrun), 16'h0);

    bitin(1); bitin(1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("clr_count", 16'(count), 16'h0);
    send(4'h4, 1'b0);
    chk("clr_4", 16'(content), 16'h4);

    send(4'hF, 1'b0);
    bitin(0); bitin(1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("rst_all", 16'({content, valid, overrun, count}), 16'h0);
    send(4'hF, 1'b0);
    chk("rst_F", 16'(content), 16'hF);

    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(99) < 2), ($urandom_range(99) < 4),
           ($urandom_range(99) < 70), 1'($urandom),
           ($urandom_range(99) < 30));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_eval, n_fail);
    $finish;
  end

endmodule
